// File: rtl/store_merge.sv
// Single-request store engine: word stores write directly, byte/half stores
// do a read-modify-write of the containing word; misaligned requests are rejected.
module store_merge #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [29:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned HALF_W  = 16;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_MERGE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Captured narrow-store context; only the low half of data can ever be merged.
  typedef struct packed {
    logic [1:0]        lo;
    logic [SIZE_W-1:0] size;
    logic [HALF_W-1:0] data;
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q, req_d;
  logic [WADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic [DATA_W-1:0]  merged;
  logic [1:0]         lane;
  logic               half_hi;
  logic               misaligned;
  logic               ready_d, rd_d, wr_d, done_d, err_d;

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane replacement of the word returned by memory.
  always_comb begin
    merged  = mem_rdata;
    lane    = req_q.lo ^ {2{BIG_ENDIAN}};
    half_hi = req_q.lo[1] ^ BIG_ENDIAN;
    if (req_q.size == SZ_BYTE) begin
      case (lane)
        2'd0:    merged[7:0]   = req_q.data[7:0];
        2'd1:    merged[15:8]  = req_q.data[7:0];
        2'd2:    merged[23:16] = req_q.data[7:0];
        default: merged[31:24] = req_q.data[7:0];
      endcase
    end else if (half_hi) begin
      merged[31:16] = req_q.data;
    end else begin
      merged[15:0] = req_q.data;
    end
  end

  // Next state, next datapath values, and next outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.lo   = req_addr[1:0];
          req_d.size = req_size;
          req_d.data = req_data[HALF_W-1:0];
          addr_d     = req_addr[31:2];
          if (misaligned) begin
            state_d = S_ERR;
          end else if (req_size == SZ_WORD) begin
            state_d = S_WR;
            wdata_d = req_data;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:    state_d = S_MERGE;
      S_MERGE: begin
        state_d = S_WR;
        wdata_d = merged;
      end
      S_WR, S_ERR: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    rd_d    = (state_d == S_RD);
    wr_d    = (state_d == S_WR);
    done_d  = (state_d == S_WR);
    err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      req_ready <= ready_d;
      mem_rd_en <= rd_d;
      mem_wr_en <= wr_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 Parameter BIG_ENDIAN, default 0, selects the byte-lane map: 0 maps lane = addr[1:0]; 1 maps lane = 3 - addr[1:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_addr  input  32  byte address of store.
REQ-007 req_data  input  32  register source data; narrow stores use low bits.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 mem_addr  output  30  word address (byte address [31:2]) to word-wide memory.
REQ-010 mem_rd_en  output  1  memory read strobe; rdata valid the cycle after.
REQ-011 mem_rdata  input  32  memory read data.
REQ-012 mem_wr_en  output  1  memory word write strobe.
REQ-013 mem_wdata  output  32  word to write.
REQ-014 done  output  1  one-cycle pulse: store committed to memory.
REQ-015 err  output  1  one-cycle pulse: request rejected (misaligned or illegal size), no memory access.

Function
REQ-016 The block SHALL implement Moore FSM states IDLE, WR, RD, MERGE, ERR; all outputs are decoded from registered state and datapath registers.
REQ-017 Accept SHALL occur when req_valid && req_ready; req_ready SHALL be 1 only in IDLE; addr, data and size are captured on accept.
REQ-018 Misalignment SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size 11; such a request transitions IDLE->ERR, ERR->IDLE, err=1 in ERR only, no rd/wr strobe.
REQ-019 An aligned word store SHALL transition IDLE->WR->IDLE; in WR: mem_wr_en=1, mem_wdata=captured data, done=1.
REQ-020 An aligned byte or half store SHALL transition IDLE->RD->MERGE->WR->IDLE (read-modify-write).
REQ-021 In RD: mem_rd_en=1, mem_addr=captured addr[31:2].
REQ-022 In MERGE, the block SHALL register mem_rdata with the selected lane(s) replaced: byte lane L writes bits [8L+7:8L] from data[7:0]; half uses lane pair H = addr[1] (BIG_ENDIAN=1: H = ~addr[1]) and writes bits [16H+15:16H] from data[15:0]; all other bits are preserved unchanged.
REQ-023 In WR after MERGE: mem_wr_en=1, mem_wdata=merged word, done=1.
REQ-024 mem_addr SHALL hold captured addr[31:2] in every non-IDLE state; in IDLE mem_addr=0, mem_wdata holds its last value, and all strobes=0.
REQ-025 Latency, accept at cycle N: word write strobe/done at N+1, ready at N+2; byte/half read at N+1, write/done at N+3, ready at N+4; error pulse at N+1, ready at N+2.
REQ-026 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle; no more than one request is in flight.
REQ-027 req_valid while busy SHALL be ignored (not captured); the requester holds it until req_ready.
REQ-028 Data width rule: req_data bits above the store size SHALL be ignored; the memory word is never sign- or zero-extended.

Reset
REQ-029 Reset SHALL force IDLE and the outputs req_ready=1, mem_rd_en=0, mem_wr_en=0, done=0, err=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted in any state, including WR, SHALL take effect at that edge; the pending write is dropped, and no done follows.
REQ-031 Reset and req_valid in the same cycle: the request SHALL NOT be accepted.

Verification
REQ-032 The bench SHALL do a word store to addr 0x100 with data 0xDEADBEEF -> next cycle wr_en=1, mem_addr=0x40, wdata=0xDEADBEEF, done=1.
REQ-033 The bench SHALL do a byte store to addr 0x103 with data 0x000000AB, memory word 0x11223344 -> RD at N+1, WR at N+3 with wdata 0xAB223344 (BIG_ENDIAN=0); wdata 0x112233AB with BIG_ENDIAN=1.
REQ-034 The bench SHALL do a half store to addr 0x202 with data 0xFFFF5678, memory word 0xAAAABBBB -> wdata 0x5678BBBB, done once.
REQ-035 The bench SHALL do a half store to addr 0x201 and, separately, size 11 -> err=1 for one cycle, no rd/wr strobes, req_ready back at N+2.
REQ-036 The bench SHALL assert reset during MERGE of a byte store -> no wr_en, no done, state IDLE, req_ready=1 next cycle.
REQ-037 The bench SHALL do back-to-back requests with req_valid held high -> second accepted only when req_ready=1, at N+4 after a byte store.
